// File: rtl/karatsuba_multiplier_seq.sv
// rtl/karatsuba_multiplier_seq.sv - sequential Karatsuba multiplier, one shared (N/2+1)-bit multiplier
// Optional signed operands: KARATSUBA_SIGNED_EN
module karatsuba_multiplier_seq #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
`ifdef KARATSUBA_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   result,
    output logic             busy
);
    localparam int H = N / 2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_P_LO, ST_P_HI, ST_P_MID, ST_COMBINE, ST_DONE
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [2*H-1:0]   r_p_lo;
    logic [2*H-1:0]   r_p_hi;
    logic [2*H+1:0]   r_p_mid;
    logic [2*N-1:0]   r_result;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_neg;

    logic [N-1:0]     w_a_in;
    logic [N-1:0]     w_b_in;
    logic             w_neg_in;
    logic [H:0]       w_sum_a;
    logic [H:0]       w_sum_b;
    logic [H:0]       w_mul_x;
    logic [H:0]       w_mul_y;
    logic [2*H+1:0]   w_mul_p;
    logic [2*H+1:0]   w_mid;
    logic [2*N-1:0]   w_comb;
    logic [2*N-1:0]   w_final;

`ifdef KARATSUBA_SIGNED_EN
    // One extra bit so that the most negative operand has a representable magnitude
    logic [N:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag;
    assign w_a_ext  = {is_signed & a[N-1], a};
    assign w_b_ext  = {is_signed & b[N-1], b};
    assign w_a_mag  = w_a_ext[N] ? (~w_a_ext + {{N{1'b0}}, 1'b1}) : w_a_ext;
    assign w_b_mag  = w_b_ext[N] ? (~w_b_ext + {{N{1'b0}}, 1'b1}) : w_b_ext;
    assign w_a_in   = w_a_mag[N-1:0];
    assign w_b_in   = w_b_mag[N-1:0];
    assign w_neg_in = w_a_ext[N] ^ w_b_ext[N];
    assign w_final  = r_neg ? (~w_comb + {{(2*N-1){1'b0}}, 1'b1}) : w_comb;
`else
    assign w_a_in   = a;
    assign w_b_in   = b;
    assign w_neg_in = 1'b0;
    assign w_final  = w_comb;
`endif

    assign w_sum_a = {1'b0, r_a[H-1:0]} + {1'b0, r_a[N-1:H]};
    assign w_sum_b = {1'b0, r_b[H-1:0]} + {1'b0, r_b[N-1:H]};

    always_comb begin
        w_mul_x = w_sum_a;
        w_mul_y = w_sum_b;
        case (r_state)
            ST_P_LO: begin
                w_mul_x = {1'b0, r_a[H-1:0]};
                w_mul_y = {1'b0, r_b[H-1:0]};
            end
            ST_P_HI: begin
                w_mul_x = {1'b0, r_a[N-1:H]};
                w_mul_y = {1'b0, r_b[N-1:H]};
            end
            default: ;
        endcase
    end

    assign w_mul_p = {{(H+1){1'b0}}, w_mul_x} * {{(H+1){1'b0}}, w_mul_y};

    // Middle term is non-negative by construction, so plain unsigned subtraction suffices
    assign w_mid  = r_p_mid - {2'b00, r_p_hi} - {2'b00, r_p_lo};
    assign w_comb = {r_p_hi, {N{1'b0}}}
                  + ({{(2*N-2*H-2){1'b0}}, w_mid} << H)
                  + {{(2*N-2*H){1'b0}}, r_p_lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_p_lo      <= '0;
            r_p_hi      <= '0;
            r_p_mid     <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_a        <= w_a_in;
                        r_b        <= w_b_in;
                        r_neg      <= w_neg_in;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_P_LO;
                    end
                end
                ST_P_LO: begin
                    r_p_lo  <= w_mul_p[2*H-1:0];
                    r_state <= ST_P_HI;
                end
                ST_P_HI: begin
                    r_p_hi  <= w_mul_p[2*H-1:0];
                    r_state <= ST_P_MID;
                end
                ST_P_MID: begin
                    r_p_mid <= w_mul_p;
                    r_state <= ST_COMBINE;
                end
                ST_COMBINE: begin
                    r_result    <= w_final;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_karatsuba_multiplier_seq.sv
// tb/tb_karatsuba_multiplier_seq.sv - vector table plus scoreboard bench for karatsuba_multiplier_seq
module tb_karatsuba_multiplier_seq;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           is_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] result;
    logic           busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]   va;
        logic [N-1:0]   vb;
        logic [2*N-1:0] vexp;
    } vec_t;

    vec_t           vecs[$];
    logic [2*N-1:0] sb_q[$];

    always #5 clk = ~clk;

    karatsuba_multiplier_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef KARATSUBA_SIGNED_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop_check(input string name);
        logic [2*N-1:0] e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: result %0h with empty scoreboard", name, result);
        end else begin
            e = sb_q.pop_front();
            chk(name, {32'd0, result}, {32'd0, e});
        end
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // One full transaction; hold>0 keeps out_ready low for that many cycles after out_valid
    task automatic do_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                         input logic [2*N-1:0] iexp, input int hold);
        bit ok;
        int j;
        out_ready = (hold == 0);
        wait_ready(ok);
        if (!ok) return;
        a = ia;
        b = ib;
        in_valid = 1'b1;
        sb_q.push_back(iexp);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        chk("busy_after_accept", 64'(busy), 64'd1);
        j = 0;
        while (!out_valid && j < 10) begin
            @(negedge clk);
            j++;
        end
        chk("latency", 64'(j), 64'd4);
        if (!out_valid) begin
            void'(sb_q.pop_front());
            return;
        end
        for (int h = 0; h < hold; h++) begin
            chk("bp_result", {32'd0, result}, {32'd0, iexp});
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        sb_pop_check("result");
        @(negedge clk);
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int seen;

        for (int ai = 1; ai <= 96; ai += 5)
            for (int bi = 1; bi <= 96; bi += 5)
                vecs.push_back('{va: 16'(ai), vb: 16'(bi), vexp: 32'(ai * bi)});
        vecs.push_back('{va: 16'hFFFF, vb: 16'hFFFF, vexp: 32'hFFFE0001});
        vecs.push_back('{va: 16'h0000, vb: 16'hABCD, vexp: 32'h00000000});

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_result", {32'd0, result}, 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        foreach (vecs[i]) do_op(vecs[i].va, vecs[i].vb, vecs[i].vexp, 0);

        do_op(16'd300, 16'd700, 32'd210000, 10);

        wait_ready(ok);
        a = 16'd1234;
        b = 16'd5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        do_op(16'd3, 16'd7, 32'd21, 0);

`ifdef KARATSUBA_SIGNED_EN
        is_signed = 1'b1;
        do_op(16'hFFFD, 16'd7, 32'hFFFFFFEB, 0);
        do_op(16'h8000, 16'h8000, 32'h40000000, 0);
        is_signed = 1'b0;
        do_op(16'h8000, 16'h8000, 32'h40000000, 0);
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/karatsuba_multiplier_seq.md
Name: karatsuba_multiplier_seq

Overview:
Multi-cycle, parametrised Karatsuba multiplier with valid/ready handshakes on both sides. It is the sequential successor to the combinational karatsuba_multiplier. It time-shares one half-width multiplier across the three Karatsuba partial products, trading latency for area. It sits on a streaming datapath, between an operand producer and a result consumer that may apply backpressure.

Parameters:
N, 16, operand width in bits; must be even and >= 4; product width is 2*N.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands a/b are valid this cycle
in_ready  output  1  block can accept operands this cycle
a  input  N  multiplicand
b  input  N  multiplier
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts result this cycle
result  output  2*N  product a*b
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk.
  - Reset values: state=IDLE, out_valid=0, result=0, busy=0, all internal registers 0.
  - in_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Split: H=N/2. aL=a[H-1:0], aH=a[N-1:H]; likewise bL and bH.
- FSM states: IDLE, P_LO, P_HI, P_MID, COMBINE, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, a and b are registered and the state goes to P_LO.
- P_LO: p_lo <= aL*bL (2H bits); next state P_HI.
- P_HI: p_hi <= aH*bH (2H bits); next state P_MID.
- P_MID: p_mid <= (aL+aH)*(bL+bH). Sums are H+1 bits and the product is 2H+2 bits. Next state COMBINE.
- All three partial products go through the same single (H+1)x(H+1) multiplier instance. Operands are zero-extended to H+1 bits where needed.
- COMBINE:
  - mid = p_mid - p_hi - p_lo, computed at 2H+2 bits; the result is never negative.
  - result <= (p_hi<<N) + (mid<<H) + p_lo, truncated to 2N bits (the true product always fits).
  - out_valid <= 1; next state DONE.
- DONE:
  - out_valid=1 and result held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid <= 0 and the state goes to IDLE.
  - result keeps its last value after the transfer.
- Latency: handshake accepted on edge k gives out_valid=1 after edge k+4.
  - No backpressure: peak throughput is one product per 6 cycles.
  - No back-to-back acceptance: in_ready=0 in DONE, even when out_ready=1.
- in_valid in any non-IDLE state is ignored, and the operands are not sampled.
- a and b may change freely after acceptance; the internal copies are used.
- Reset during any state: the operation in flight is discarded and out_valid drops on the next edge. No partial result is ever presented.
- busy=1 in P_LO through DONE.
- X-safety: out_valid and in_ready are never X after the first reset edge.

Optional Feature:
Macro: KARATSUBA_SIGNED_EN.
- Defined:
  - An extra input port is_signed (1 bit) is sampled together with a and b at acceptance.
  - When is_signed=1, a and b are two's complement. Magnitudes |a| and |b| are computed at acceptance (N+1-bit internal width, so that -2^(N-1) is handled) and fed through the same unsigned Karatsuba sequence.
  - At COMBINE, result is negated when sign(a) XOR sign(b) = 1. The 2N-bit result is then the two's-complement product.
  - Latency is unchanged.
- Undefined:
  - The is_signed port does not exist.
  - Operands are always unsigned.
  - The N+1-bit magnitude path is not synthesised.

Test Plan:
- Reset then idle, in_valid=0 -> in_ready=1, out_valid=0, result=0, busy=0.
- N=16, a=1..96 step 5, b=1..96 step 5 (400 pairs), out_ready=1 -> result==a*b for every pair. out_valid rises exactly 4 edges after acceptance and stays high for 1 cycle.
- N=16, a=16'hFFFF, b=16'hFFFF -> result=32'hFFFE0001. Also a=0, b=16'hABCD -> result=0, which checks the p_mid carry bits and the zero path.
- Backpressure: a=300, b=700, out_ready held 0 for 10 cycles after out_valid -> result stays 210000 and in_ready=0 throughout. Raising out_ready for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-operation: accept a=1234, b=5678, then drive rst_n=0 in P_HI for 1 cycle -> out_valid never asserts for that pair. The next request a=3, b=7 returns 21.
- With KARATSUBA_SIGNED_EN, N=16, is_signed=1:
  - a=-3, b=7 -> result=32'hFFFFFFEB.
  - a=16'h8000, b=16'h8000 -> result=32'h40000000.
  - With is_signed=0 and the same bit patterns -> result=32'h40000000.
